// File: rtl/divider_iterative.sv
// Iterative restoring divider: one quotient bit per clock on operand
// magnitudes, sign-corrected result registered on the final iteration.
module divider_iterative #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd;       // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dvs;       // divisor magnitude
   logic [WIDTH-1:0] rem;       // partial remainder (always < dvs)
   logic             q_neg;
   logic             r_neg;
   logic             div_zero;
   logic [WIDTH-1:0] a_raw;     // original dividend, returned on divide by zero

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   diff;
   logic             ge;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] dvd_next;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   // Operand magnitudes and one restoring step with WIDTH+1-bit subtract
   always_comb begin
      a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
      b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
      rem_shift = {rem, dvd[WIDTH-1]};
      diff      = rem_shift - {1'b0, dvs};
      ge        = ~diff[WIDTH];
      rem_next  = ge ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      dvd_next  = {dvd[WIDTH-2:0], ge};
      q_fix     = q_neg ? -dvd_next : dvd_next;
      r_fix     = r_neg ? -rem_next : rem_next;
   end

   // Control FSM, working registers and registered result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         cnt       <= '0;
         dvd       <= '0;
         dvs       <= '0;
         rem       <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         div_zero  <= 1'b0;
         a_raw     <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state    <= S_BUSY;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  cnt      <= CW'(WIDTH);
                  dvd      <= a_mag;
                  dvs      <= b_mag;
                  rem      <= '0;
                  q_neg    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_neg    <= is_signed && a[WIDTH-1];
                  div_zero <= (b == '0);
                  a_raw    <= a;
               end
            end
            S_BUSY: begin
               dvd <= dvd_next;
               rem <= rem_next;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state     <= S_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  quotient  <= div_zero ? '1 : q_fix;
                  remainder <= div_zero ? a_raw : r_fix;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_iterative.sv
// Directed and swept checks for divider_iterative (WIDTH=32).
module tb_divider_iterative;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int checks   = 0;
   int failures = 0;

   divider_iterative #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Behavioural reference, independent of the iterative datapath
   task automatic ref_div(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] q, output logic [31:0] r);
      if (y == 32'h0) begin
         q = 32'hFFFF_FFFF;
         r = x;
      end else if (sgn) begin
         if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
         end else begin
            q = 32'($signed(x) / $signed(y));
            r = 32'($signed(x) % $signed(y));
         end
      end else begin
         q = x / y;
         r = x % y;
      end
   endtask

   // One operation; optional ignored start pulse during BUSY at edge 'glitch'
   task automatic run_op(input logic sgn, input logic [31:0] aa, input logic [31:0] bb,
                         input int glitch,
                         output logic [31:0] q, output logic [31:0] r, output int lat,
                         output logic busy_acc, output logic done_acc,
                         output logic [31:0] q_acc);
      @(negedge clk);
      start     = 1'b1;
      is_signed = sgn;
      a         = aa;
      b         = bb;
      @(posedge clk);
      #1;
      start     = 1'b0;
      is_signed = ~sgn;
      a         = 32'hDEAD_BEEF;
      b         = 32'h0000_0003;
      busy_acc  = busy;
      done_acc  = done;
      q_acc     = quotient;
      lat       = 0;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == glitch) begin
            start = 1'b1;
            a     = 32'd1000;
            b     = 32'd3;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      q     = quotient;
      r     = remainder;
   endtask

   initial begin
      logic [31:0] q, r, eq, er, qa, sa, sb;
      logic        ba, da;
      int          lat;

      reset     = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      a         = 32'h0;
      b         = 32'h0;
      #12;
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_done", {31'h0, done}, 32'h0);
      check("reset_q", quotient, 32'h0);
      check("reset_r", remainder, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Unsigned 100/7 with exact latency
      run_op(1'b0, 32'd100, 32'd7, 0, q, r, lat, ba, da, qa);
      check("u100_7_busy_at_accept", {31'h0, ba}, 32'h1);
      check("u100_7_latency", 32'(lat), 32'd32);
      check("u100_7_q", q, 32'd14);
      check("u100_7_r", r, 32'd2);

      // Back-to-back start from DONE; old result holds until the new one
      run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, q, r, lat, ba, da, qa);
      check("b2b_busy_at_accept", {31'h0, ba}, 32'h1);
      check("b2b_done_at_accept", {31'h0, da}, 32'h0);
      check("b2b_q_held", qa, 32'd14);
      check("s-7_2_q", q, 32'hFFFF_FFFD);
      check("s-7_2_r", r, 32'hFFFF_FFFF);

      run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 0, q, r, lat, ba, da, qa);
      check("s7_-2_q", q, 32'hFFFF_FFFD);
      check("s7_-2_r", r, 32'h0000_0001);

      // Divide by zero, both modes
      run_op(1'b0, 32'h1234_5678, 32'h0, 0, q, r, lat, ba, da, qa);
      check("udiv0_latency", 32'(lat), 32'd32);
      check("udiv0_q", q, 32'hFFFF_FFFF);
      check("udiv0_r", r, 32'h1234_5678);
      run_op(1'b1, 32'h1234_5678, 32'h0, 0, q, r, lat, ba, da, qa);
      check("sdiv0_q", q, 32'hFFFF_FFFF);
      check("sdiv0_r", r, 32'h1234_5678);
      run_op(1'b1, 32'hFFFF_FFF9, 32'h0, 0, q, r, lat, ba, da, qa);
      check("sdiv0_neg_q", q, 32'hFFFF_FFFF);
      check("sdiv0_neg_r", r, 32'hFFFF_FFF9);

      // Most negative dividend by -1 / 0xFFFFFFFF
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, q, r, lat, ba, da, qa);
      check("sovf_q", q, 32'h8000_0000);
      check("sovf_r", r, 32'h0);
      run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, q, r, lat, ba, da, qa);
      check("u8000_ffff_q", q, 32'h0);
      check("u8000_ffff_r", r, 32'h8000_0000);

      // Start pulse during BUSY must be ignored
      run_op(1'b0, 32'd100, 32'd7, 5, q, r, lat, ba, da, qa);
      check("ignore_start_latency", 32'(lat), 32'd32);
      check("ignore_start_q", q, 32'd14);
      check("ignore_start_r", r, 32'd2);
      repeat (3) @(posedge clk);
      #1;
      check("ignore_start_stays_done", {31'h0, done}, 32'h1);

      // Asynchronous reset mid-operation, between edges
      @(negedge clk);
      start     = 1'b1;
      is_signed = 1'b0;
      a         = 32'd500;
      b         = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("midrst_busy", {31'h0, busy}, 32'h0);
      check("midrst_done", {31'h0, done}, 32'h0);
      check("midrst_q", quotient, 32'h0);
      check("midrst_r", remainder, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      run_op(1'b0, 32'd500, 32'd9, 0, q, r, lat, ba, da, qa);
      check("after_rst_latency", 32'(lat), 32'd32);
      check("after_rst_q", q, 32'd55);
      check("after_rst_r", r, 32'd5);

      // Stepping-operand sweep against the reference
      sa = 32'h0000_0001;
      sb = 32'h0000_0005;
      for (int i = 0; i < 1000; i++) begin
         run_op(1'(i & 1), sa, sb, 0, q, r, lat, ba, da, qa);
         ref_div(1'(i & 1), sa, sb, eq, er);
         check("sweep_q", q, eq);
         check("sweep_r", r, er);
         sa = sa + 32'h2345_6789;
         sb = sb + 32'h3456_7891;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
